// File: rtl/output_stream_buffer.sv
// output_stream_buffer: captures finished output pixels, saturates them to OUT_WIDTH,
// queues them in a FIFO, and presents the FIFO to the host as a valid/ready stream.
// Optional feature macro: OUTBUF_RELU_EN (negative accumulators are zeroed before saturation).
module output_stream_buffer #(
   parameter int unsigned ACC_WIDTH          = 32,
   parameter int unsigned OUT_WIDTH          = 16,
   parameter int unsigned FIFO_DEPTH         = 8,
   parameter int unsigned ALMOST_FULL_MARGIN = 2,
   parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
   parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
   parameter int unsigned OUTPUT_NB_CHANNELS = 64
) (
   input  logic                 clk,
   input  logic                 arst_n_in,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [ACC_WIDTH-1:0] in_data,
   input  logic [31:0]          in_x,
   input  logic [31:0]          in_y,
   input  logic [31:0]          in_ch,
   output logic                 in_stall,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [31:0]          out_x,
   output logic [31:0]          out_y,
   output logic [31:0]          out_ch,
   output logic                 overflow,
   output logic                 done,
   output logic [31:0]          out_count
);

   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned TOTAL     = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
   localparam int unsigned STALL_LVL = FIFO_DEPTH - ALMOST_FULL_MARGIN;
   localparam int unsigned UPPER_W   = ACC_WIDTH - OUT_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [OUT_WIDTH-1:0] data;
      logic [31:0]          x;
      logic [31:0]          y;
      logic [31:0]          ch;
   } entry_t;

   state_t               state, state_next;
   entry_t               mem [FIFO_DEPTH];
   entry_t               entry;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count, count_next;
   logic [31:0]          acc_cnt;
   logic                 push_attempt, clear_run, done_next;
   logic                 pop, full, push, drop;
   logic [ACC_WIDTH-1:0] relu;
   logic [UPPER_W-1:0]   upper;
   logic [OUT_WIDTH-1:0] sat;

   // State register
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) state <= S_IDLE;
      else            state <= state_next;
   end

   // Next-state logic; the final accepted input moves the run into DRAIN
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:   if (start) state_next = S_STREAM;
         S_STREAM: if (in_valid && (acc_cnt == 32'(TOTAL - 1))) state_next = S_DRAIN;
         S_DRAIN:  if (count == '0) state_next = S_DONE;
         S_DONE:   if (start) state_next = S_STREAM;
         default:  state_next = S_IDLE;
      endcase
   end

   // FSM-derived controls
   always_comb begin
      push_attempt = 1'b0;
      clear_run    = 1'b0;
      done_next    = (state_next == S_DONE);
      if (state == S_STREAM) push_attempt = in_valid;
      if ((state == S_IDLE) || (state == S_DONE)) clear_run = start;
   end

   // Optional ReLU followed by a signed clamp to the output word range
   always_comb begin
      relu = in_data;
`ifdef OUTBUF_RELU_EN
      if (in_data[ACC_WIDTH-1]) relu = '0;
`endif
      upper = relu[ACC_WIDTH-1:OUT_WIDTH-1];
      sat   = relu[OUT_WIDTH-1:0];
      if (!((&upper) || !(|upper))) begin
         if (relu[ACC_WIDTH-1]) sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
         else                   sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
      entry = '{data: sat, x: in_x, y: in_y, ch: in_ch};
   end

   // FIFO handshake; a full FIFO still accepts a push when a pop frees a slot in the same cycle
   always_comb begin
      pop        = out_valid && out_ready;
      full       = (count == CNT_W'(FIFO_DEPTH));
      push       = push_attempt && (!full || pop);
      drop       = push_attempt && full && !pop;
      count_next = count + CNT_W'(push) - CNT_W'(pop);
   end

   // FIFO storage, pointers, counters and registered status
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         acc_cnt   <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
         in_stall  <= 1'b0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= done_next;
         if (clear_run) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc_cnt   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_stall  <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= entry;
               wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr    <= rd_ptr + PTR_W'(1);
               out_count <= out_count + 32'd1;
            end
            if (push_attempt) acc_cnt  <= acc_cnt + 32'd1;
            if (drop)         overflow <= 1'b1;
            count     <= count_next;
            out_valid <= (count_next != '0);
            in_stall  <= (count_next >= CNT_W'(STALL_LVL));
         end
      end
   end

   // Head entry is read straight from registered storage
   always_comb begin
      out_data = mem[rd_ptr].data;
      out_x    = mem[rd_ptr].x;
      out_y    = mem[rd_ptr].y;
      out_ch   = mem[rd_ptr].ch;
   end

endmodule

// File: tb/tb_output_stream_buffer.sv
// Directed bench for output_stream_buffer: one 1x1x4 instance and one 2x2x4 instance share stimulus.
module tb_output_stream_buffer;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic        start, in_valid, out_ready;
   logic [31:0] in_data, in_x, in_y, in_ch;

   logic        a_stall, a_valid, a_ovf, a_done;
   logic [15:0] a_data;
   logic [31:0] a_x, a_y, a_ch, a_count;
   logic        b_stall, b_valid, b_ovf, b_done;
   logic [15:0] b_data;
   logic [31:0] b_x, b_y, b_ch, b_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   output_stream_buffer #(.FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1), .OUTPUT_NB_CHANNELS(4)) ua (
      .clk(clk), .arst_n_in(arst_n_in), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .in_stall(a_stall), .out_valid(a_valid),
      .out_ready(out_ready), .out_data(a_data), .out_x(a_x), .out_y(a_y), .out_ch(a_ch),
      .overflow(a_ovf), .done(a_done), .out_count(a_count));

   output_stream_buffer #(.FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(4)) ub (
      .clk(clk), .arst_n_in(arst_n_in), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .in_stall(b_stall), .out_valid(b_valid),
      .out_ready(out_ready), .out_data(b_data), .out_x(b_x), .out_y(b_y), .out_ch(b_ch),
      .overflow(b_ovf), .done(b_done), .out_count(b_count));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n_in = 1'b0;
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      tick();
      arst_n_in = 1'b1;
      tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input logic [31:0] x, input logic [31:0] y, input logic [31:0] ch);
      in_valid = 1'b1;
      in_data  = d;
      in_x     = x;
      in_y     = y;
      in_ch    = ch;
      tick();
   endtask

   // Pop n entries from dut b, expecting data == x == base+i
   task automatic drain_b(input int n, input int base);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         check("drain_valid", 32'(b_valid), 32'd1);
         check("drain_data", 32'(b_data), 32'(base + i));
         check("drain_x", b_x, 32'(base + i));
         tick();
      end
      out_ready = 1'b0;
   endtask

   initial begin
      int  sent, recv, wait_cyc;
      logic early_done;
      arst_n_in = 1'b0;
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_x = '0; in_y = '0; in_ch = '0;

      // Reset values
      #3;
      check("rst_valid", 32'(b_valid), 32'd0);
      check("rst_data", 32'(b_data), 32'd0);
      check("rst_x", b_x, 32'd0);
      check("rst_stall", 32'(b_stall), 32'd0);
      check("rst_ovf", 32'(b_ovf), 32'd0);
      check("rst_done", 32'(b_done), 32'd0);
      check("rst_count", b_count, 32'd0);
      do_reset();

      // 1x1x4 run, back-to-back pushes with out_ready high
      do_start();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(32'(10 * (i + 1)), 32'd0, 32'd0, 32'(i));
         check("t1_valid", 32'(a_valid), 32'd1);
         check("t1_data", 32'(a_data), 32'(10 * (i + 1)));
         check("t1_ch", a_ch, 32'(i));
      end
      in_valid = 1'b0;
      tick();
      check("t1_count", a_count, 32'd4);
      check("t1_done_early", 32'(a_done), 32'd0);
      tick();
      check("t1_done", 32'(a_done), 32'd1);
      check("t1_ovf", 32'(a_ovf), 32'd0);

      // Fill with no backpressure relief: stall hint, drop of the 9th entry
      do_reset();
      do_start();
      for (int k = 1; k <= 9; k++) begin
         push(32'(100 + k - 1), 32'(100 + k - 1), 32'd0, 32'd0);
         check("t2_stall", 32'(b_stall), (k >= 6) ? 32'd1 : 32'd0);
         check("t2_ovf", 32'(b_ovf), (k == 9) ? 32'd1 : 32'd0);
      end
      in_valid = 1'b0;
      drain_b(8, 100);
      check("t2_empty", 32'(b_valid), 32'd0);
      check("t2_count", b_count, 32'd8);
      check("t2_ovf_sticky", 32'(b_ovf), 32'd1);

      // Full FIFO with simultaneous push and pop
      do_reset();
      do_start();
      for (int k = 0; k < 8; k++) push(32'(200 + k), 32'(200 + k), 32'd0, 32'd0);
      out_ready = 1'b1;
      push(32'd208, 32'd208, 32'd0, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("t3_ovf", 32'(b_ovf), 32'd0);
      check("t3_stall", 32'(b_stall), 32'd1);
      check("t3_head", 32'(b_data), 32'd201);
      push(32'd209, 32'd209, 32'd0, 32'd0);
      in_valid = 1'b0;
      check("t3_still_full", 32'(b_ovf), 32'd1);
      drain_b(8, 201);
      check("t3_empty", 32'(b_valid), 32'd0);

      // Saturation / optional ReLU
      do_reset();
      do_start();
      push(32'd70000, 32'd1, 32'd0, 32'd0);
      push(-32'sd70000, 32'd2, 32'd0, 32'd0);
      push(32'd1234, 32'd3, 32'd0, 32'd0);
      push(-32'sd5, 32'd4, 32'd0, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("sat_pos", 32'(b_data), 32'h7FFF);
      tick();
`ifdef OUTBUF_RELU_EN
      check("sat_neg", 32'(b_data), 32'h0000);
`else
      check("sat_neg", 32'(b_data), 32'h8000);
`endif
      tick();
      check("sat_pass", 32'(b_data), 32'd1234);
      tick();
`ifdef OUTBUF_RELU_EN
      check("sat_small_neg", 32'(b_data), 32'h0000);
`else
      check("sat_small_neg", 32'(b_data), 32'hFFFB);
`endif
      tick();
      out_ready = 1'b0;

      // 2x2x4 run with random backpressure; producer honours the stall hint
      do_reset();
      do_start();
      sent = 0; recv = 0; early_done = 1'b0;
      for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
         if (b_done) early_done = 1'b1;
         if (sent < 16 && !b_stall) begin
            in_valid = 1'b1;
            in_data  = 32'(sent * 3 + 1);
            in_x     = 32'(sent % 2);
            in_y     = 32'((sent / 2) % 2);
            in_ch    = 32'(sent / 4);
            sent++;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (b_valid && out_ready) begin
            check("t5_data", 32'(b_data), 32'(recv * 3 + 1));
            check("t5_x", b_x, 32'(recv % 2));
            check("t5_y", b_y, 32'((recv / 2) % 2));
            check("t5_ch", b_ch, 32'(recv / 4));
            recv++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("t5_recv", 32'(recv), 32'd16);
      check("t5_early_done", 32'(early_done), 32'd0);
      wait_cyc = 0;
      while (!b_done && wait_cyc < 10) begin
         tick();
         wait_cyc++;
      end
      check("t5_done", 32'(b_done), 32'd1);
      check("t5_count", b_count, 32'd16);
      check("t5_ovf", 32'(b_ovf), 32'd0);

      // Asynchronous reset mid-run with entries queued
      do_reset();
      do_start();
      for (int k = 0; k < 3; k++) push(32'(50 + k), 32'(50 + k), 32'd7, 32'd9);
      in_valid = 1'b0;
      check("t6_queued", 32'(b_valid), 32'd1);
      #2;
      arst_n_in = 1'b0;
      #1;
      check("t6_rst_valid", 32'(b_valid), 32'd0);
      check("t6_rst_data", 32'(b_data), 32'd0);
      check("t6_rst_y", b_y, 32'd0);
      tick();
      arst_n_in = 1'b1;
      push(32'd66, 32'd66, 32'd0, 32'd0);
      in_valid = 1'b0;
      check("t6_idle_ignore", 32'(b_valid), 32'd0);
      do_start();
      check("t6_count_clr", b_count, 32'd0);
      push(32'd77, 32'd77, 32'd0, 32'd0);
      in_valid = 1'b0;
      check("t6_head", 32'(b_data), 32'd77);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t6_count", b_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/output_stream_buffer.md
# output_stream_buffer

Downstream stage of the convolution controller/MAC datapath. Captures each finished output pixel (accumulator value plus x/y/output-channel coordinates, flagged by the controller's output-valid strobe), saturates it to the output word width, and queues it in a FIFO. It presents the FIFO to the host over a valid/ready stream. It raises a stall hint before the FIFO fills and reports completion once every output of the feature map has been drained.

## Interface
- ACC_WIDTH, 32: accumulator input width (signed)
- OUT_WIDTH, 16: output word width (signed), OUT_WIDTH < ACC_WIDTH
- FIFO_DEPTH, 8: entries; power of two, >= 4
- ALMOST_FULL_MARGIN, 2: free-entry threshold for `in_stall`; 1..FIFO_DEPTH-1
- FEATURE_MAP_WIDTH, 1024; FEATURE_MAP_HEIGHT, 1024; OUTPUT_NB_CHANNELS, 64: TOTAL = W*H*C outputs per run
- clk  in  1  clock; all logic on rising edge
- arst_n_in  in  1  asynchronous reset, active low
- start  in  1  begin a run (level-sampled)
- in_valid  in  1  output pixel present this cycle
- in_data  in  ACC_WIDTH  signed accumulator value
- in_x, in_y, in_ch  in  32 each  pixel coordinates
- in_stall  out  1  FIFO at/above almost-full
- out_valid  out  1  head entry valid
- out_ready  in  1  host accepts head entry
- out_data  out  OUT_WIDTH  saturated value
- out_x, out_y, out_ch  out  32 each  head-entry coordinates
- overflow  out  1  sticky: an input was dropped
- done  out  1  run complete, FIFO empty
- out_count  out  32  entries popped this run

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: `start`=1 -> STREAM; clears the accepted counter, `out_count`, `overflow` and FIFO pointers.
- STREAM: every cycle with `in_valid`=1 performs a push attempt and increments the accepted counter, whether or not the entry is stored. When the counter reaches TOTAL, the state goes to DRAIN on the next edge.
- DRAIN: pushes are ignored. FIFO empty and no pop in progress -> DONE.
- DONE: `done`=1. `start`=1 -> STREAM with the same clears as from IDLE.
- `in_valid` in IDLE/DRAIN/DONE: ignored. Does not count and does not set `overflow`.
- Pop: `out_valid && out_ready`. Advances the read pointer and increments `out_count`.
- Full-FIFO push:
  - A pop in the same cycle frees a slot, so the push is stored and occupancy is unchanged.
  - With no pop, the entry is dropped and `overflow` is set; it stays set until the next start/reset.
- Empty FIFO: `out_valid`=0; `out_ready` has no effect.
- Saturation is applied on write, as a signed clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. For OUT_WIDTH=16, 70000 -> 32767 and -70000 -> -32768. In-range values pass through exactly, sign-truncated.
- Coordinates are stored unmodified.
- `in_stall` = occupancy >= FIFO_DEPTH - ALMOST_FULL_MARGIN, computed from registered occupancy. It is a hint only; the controller does not have to obey it.
- Occupancy counter width: clog2(FIFO_DEPTH)+1.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, coordinates 0
  - `in_stall`=0, `overflow`=0, `done`=0, `out_count`=0
  - state IDLE
- Reset mid-run: FIFO contents discarded immediately (asynchronous), all outputs at reset values.
- Push-to-visibility latency: 1 cycle. An entry pushed at edge N, into an empty FIFO, drives `out_valid`=1 from edge N onward (registered storage, no combinational in->out path).
- `out_*` are held stable while `out_valid`=1 and `out_ready`=0.
- `in_stall`, `done` and `overflow` update on the edge after the causing event.
- Throughput: one push and one pop per cycle sustained.
- `start` while in STREAM/DRAIN: ignored.

## Configuration
- OUTBUF_RELU_EN defined: negative `in_data` is replaced by 0 before saturation (-5 -> 0, -70000 -> 0).
- OUTBUF_RELU_EN not defined: signed saturation only (-5 -> -5).

## Test plan
- W=H=1, C=4: start, push 10,20,30,40 back-to-back with `out_ready`=1.
  - Outputs appear in order one cycle after each push.
  - `out_count`=4, then `done`=1; `overflow`=0.
- FIFO_DEPTH=8, `out_ready`=0: push 9 entries.
  - `in_stall`=1 after the 6th push.
  - 9th push dropped, `overflow`=1.
  - Draining yields exactly the first 8 entries in order.
- Full FIFO, push and pop in the same cycle: no drop, `overflow`=0, occupancy stays 8.
- Saturation: push 70000, -70000, 1234.
  - Without the macro: outputs 32767, -32768, 1234.
  - With OUTBUF_RELU_EN: outputs 32767, 0, 1234.
- Random `out_ready` backpressure (50%) over a W=2, H=2, C=4 run: all 16 entries received with correct x/y/ch and in order; `done` only after the last pop.
- Assert `arst_n_in`=0 with 3 entries queued: `out_valid`=0 immediately, state IDLE. `start` then restarts with `out_count`=0.
